// File: rtl/bin_to_gray_pkg.sv
// Shared width constant and Gray-code helper functions for the
// bin_to_gray converter and its optional self-check.
package bin_to_gray_pkg;

  localparam int GRAY_W = 4;

  // Reflected Gray encoding: each bit is the XOR of itself and its upper neighbour.
  function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Prefix-XOR decoding from the MSB downward.
  function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] gray);
    logic [GRAY_W-1:0] bin;
    bin[GRAY_W-1] = gray[GRAY_W-1];
    for (int i = GRAY_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/bin_to_gray_chk.sv
// gray_to_bin_chk: decodes the registered Gray outputs back to binary and
// compares them against the binary input delayed by one cycle. Any
// disagreement raises err on the following clock edge. Only built when
// BIN_TO_GRAY_CHECK_EN is defined.
module gray_to_bin_chk
  import bin_to_gray_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [GRAY_W-1:0] bin_in,
  input  logic [GRAY_W-1:0] gray_in,
  output logic              err
);

  logic [GRAY_W-1:0] bin_dly_d;
  logic [GRAY_W-1:0] bin_dly_q;
  logic              err_d;
  logic              err_q;

  // Next-state: track the input one cycle late; flag any decode disagreement.
  always_comb begin
    bin_dly_d = bin_in;
    err_d     = (gray2bin(gray_in) != bin_dly_q);
  end

  // Delay register and error flop; both clear while rst is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_dly_q <= '0;
      err_q     <= 1'b0;
    end else begin
      bin_dly_q <= bin_dly_d;
      err_q     <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: rtl/bin_to_gray.sv
// bin_to_gray: registered 4-bit binary-to-Gray converter with one cycle
// of latency. Optional decode-and-compare self-check is enabled by
// defining BIN_TO_GRAY_CHECK_EN; otherwise err is tied low.
module bin_to_gray
  import bin_to_gray_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic D,
  output logic G3,
  output logic G2,
  output logic G1,
  output logic G0,
  output logic err
);

  logic [GRAY_W-1:0] bin;
  logic [GRAY_W-1:0] gray_d;
  logic [GRAY_W-1:0] gray_q;

  assign bin = {A, B, C, D};

  // Encode the current binary input every cycle; there is no enable.
  always_comb begin
    gray_d = bin2gray(bin);
  end

  // Output register; reset discards any pending conversion immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gray_q <= '0;
    end else begin
      gray_q <= gray_d;
    end
  end

  assign {G3, G2, G1, G0} = gray_q;

`ifdef BIN_TO_GRAY_CHECK_EN
  gray_to_bin_chk u_chk (
    .clk     (clk),
    .rst     (rst),
    .bin_in  (bin),
    .gray_in (gray_q),
    .err     (err)
  );
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bin_to_gray.sv
// Scoreboard bench for bin_to_gray: stimulus pushes expected Gray codes
// into a queue, a monitor pops and compares one cycle after each edge.
module tb_bin_to_gray;

  logic clk = 1'b0;
  logic rst;
  logic A, B, C, D;
  logic G3, G2, G1, G0;
  logic err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] exp_g;
    bit         step_chk;
  } exp_t;

  exp_t sb_q[$];

  // Reflected Gray code table, binary 0..15 in order.
  int gray_tab [16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

  logic [3:0] prev_g = 4'b0000;

  bin_to_gray dut (
    .clk (clk), .rst (rst),
    .A (A), .B (B), .C (C), .D (D),
    .G3 (G3), .G2 (G2), .G1 (G1), .G0 (G0),
    .err (err)
  );

  always #5 clk = ~clk;

  function automatic int ones(input logic [3:0] v);
    int n = 0;
    for (int i = 0; i < 4; i++) if (v[i] === 1'b1) n++;
    return n;
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, req);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge and queue what the
  // outputs must show after the next rising edge.
  task automatic cycle(input logic [3:0] bin, input bit rst_v, input bit step);
    exp_t e;
    @(negedge clk);
    rst = rst_v;
    {A, B, C, D} = bin;
    e.exp_g    = rst_v ? 4'b0000 : 4'(gray_tab[bin]);
    e.step_chk = step;
    sb_q.push_back(e);
    @(posedge clk);
  endtask

  // Monitor: compare outputs and err against the queue head just after each edge.
  initial begin
    exp_t e;
    logic [3:0] g;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        g = {G3, G2, G1, G0};
        check("gray_out", g, e.exp_g);
        check("err_low", {3'b000, err}, 4'b0000);
        if (e.step_chk) begin
          checks++;
          if (ones(g ^ prev_g) != 1) begin
            errors++;
            $display("FAIL one_bit_step prev=%b actual=%b required_bits_changed=1", prev_g, g);
          end
        end
        prev_g = g;
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] r;
    // Reset with inputs 1111: outputs clear without any clock edge.
    rst = 1'b1;
    {A, B, C, D} = 4'b1111;
    #1;
    check("reset_gray", {G3, G2, G1, G0}, 4'b0000);
    check("reset_err", {3'b000, err}, 4'b0000);
    cycle(4'b1111, 1'b1, 1'b0);
    cycle(4'b1111, 1'b0, 1'b0);          // first edge after release -> 1000

    // Single values.
    cycle(4'b0101, 1'b0, 1'b0);
    cycle(4'b1000, 1'b0, 1'b0);
    cycle(4'b0011, 1'b0, 1'b0);
    cycle(4'b1111, 1'b0, 1'b0);

    // Sweep 0..15 then wrap to 0; every step must change exactly one bit.
    cycle(4'd0, 1'b0, 1'b0);
    for (int i = 1; i < 16; i++) cycle(4'(i), 1'b0, 1'b1);
    cycle(4'd0, 1'b0, 1'b1);

    // Mid-stream reset between edges.
    cycle(4'b1010, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midreset_async", {G3, G2, G1, G0}, 4'b0000);
    begin
      exp_t e;
      e.exp_g = 4'b0000; e.step_chk = 1'b0;
      sb_q.push_back(e);
    end
    @(posedge clk);
    cycle(4'b0110, 1'b1, 1'b0);
    cycle(4'b0110, 1'b0, 1'b0);          // current input after release -> 0101

    // Randomized conversions.
    for (int i = 0; i < 40; i++) begin
      r = 4'($urandom_range(0, 15));
      cycle(r, 1'b0, 1'b0);
    end

`ifdef BIN_TO_GRAY_CHECK_EN
    // Corrupt the output register and expect err on the following edge.
    @(negedge clk);
    {A, B, C, D} = 4'b0101;
    @(negedge clk);
    force dut.gray_q = 4'b0111 ^ 4'b0001;
    @(posedge clk);
    #1;
    check("err_on_fault", {3'b000, err}, 4'b0001);
    @(negedge clk);
    release dut.gray_q;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("err_recovers", {3'b000, err}, 4'b0000);
`endif

    @(posedge clk);
    #3;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
